// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle core.
//   opcode_t : 4-bit opcode values (8..15 are not enumerated and execute as NOOP)
//   state_t  : 4-bit controller state encoding, visible on the State output
//   *_MSB/_LSB : bit positions of the instruction-word fields
package mc_pkg;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'd0,
    OP_STORE = 4'd1,
    OP_LOAD  = 4'd2,
    OP_ADD   = 4'd3,
    OP_SUB   = 4'd4,
    OP_HALT  = 4'd5,
    OP_LDI   = 4'd6,
    OP_JZ    = 4'd7
  } opcode_t;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LOAD_A = 4'd3,
    S_LOAD_B = 4'd4,
    S_STORE  = 4'd5,
    S_ALU    = 4'd6,
    S_LDI    = 4'd7,
    S_JZ     = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  // Instruction field positions
  localparam int OP_MSB    = 15;
  localparam int OP_LSB    = 12;
  localparam int RA_MSB    = 11;
  localparam int RA_LSB    = 8;
  localparam int RB_MSB    = 7;
  localparam int RB_LSB    = 4;
  localparam int RD_MSB    = 3;
  localparam int RD_LSB    = 0;
  localparam int LADDR_MSB = 11;  // LOAD data address
  localparam int LADDR_LSB = 4;
  localparam int SADDR_MSB = 7;   // STORE data address
  localparam int SADDR_LSB = 0;
  localparam int IMM_MSB   = 11;  // LDI immediate
  localparam int IMM_LSB   = 4;
  localparam int JT_MSB    = 7;   // JZ target
  localparam int JT_LSB    = 0;

endpackage

// File: rtl/multicycle_core_if.sv
// Memory-side bus of the multicycle core.
//   IM_Addr/IM_Data : synchronous instruction ROM (data one cycle after address)
//   D_Addr/D_Wr/D_WData/D_RData : data memory (read data one cycle after address)
// modport master = core side, modport slave = memory side.
interface multicycle_core_if #(
  parameter int DW   = 16,
  parameter int PC_W = 7
);
  logic [PC_W-1:0] IM_Addr;
  logic [15:0]     IM_Data;
  logic [7:0]      D_Addr;
  logic            D_Wr;
  logic [DW-1:0]   D_WData;
  logic [DW-1:0]   D_RData;

  modport master (
    output IM_Addr, D_Addr, D_Wr, D_WData,
    input  IM_Data, D_RData
  );

  modport slave (
    input  IM_Addr, D_Addr, D_Wr, D_WData,
    output IM_Data, D_RData
  );
endinterface

// File: rtl/mc_regfile.sv
// Register file for the multicycle core.
//   clk, rst         : clock, asynchronous active-high reset (clears all registers)
//   ra_addr/ra_data  : combinational read port A
//   rb_addr/rb_data  : combinational read port B
//   we/wa/wd         : synchronous write port
// Addresses at or above NREG read as zero and ignore writes.
module mc_regfile #(
  parameter int NREG = 16,
  parameter int DW   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    ra_addr,
  input  logic [3:0]    rb_addr,
  output logic [DW-1:0] ra_data,
  output logic [DW-1:0] rb_data,
  input  logic          we,
  input  logic [3:0]    wa,
  input  logic [DW-1:0] wd
);
  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [DW-1:0] regs [NREG];

  logic ra_ok, rb_ok, wa_ok;
  assign ra_ok = 32'(ra_addr) < NREG;
  assign rb_ok = 32'(rb_addr) < NREG;
  assign wa_ok = 32'(wa) < NREG;

  assign ra_data = ra_ok ? regs[ra_addr[AW-1:0]] : '0;
  assign rb_data = rb_ok ? regs[rb_addr[AW-1:0]] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && wa_ok) begin
      regs[wa[AW-1:0]] <= wd;
    end
  end
endmodule

// File: rtl/multicycle_core.sv
// Multicycle 16-bit-instruction processor core.
//   Clk, Reset : clock, asynchronous active-high reset
//   Run        : resumes execution from HALT (ignored elsewhere)
//   bus        : instruction ROM and data memory (multicycle_core_if.master)
//   IR_Out     : instruction register
//   PC_Out     : program counter (also driven on bus.IM_Addr)
//   State      : current controller state (mc_pkg::state_t encoding)
//   Halted     : high while in HALT
module multicycle_core
  import mc_pkg::*;
#(
  parameter int DW   = 16,
  parameter int PC_W = 7,
  parameter int NREG = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Run,
  multicycle_core_if.master    bus,
  output logic [15:0]          IR_Out,
  output logic [PC_W-1:0]      PC_Out,
  output logic [3:0]           State,
  output logic                 Halted
);
  state_t          state, next_state;
  logic [PC_W-1:0] pc;
  logic [15:0]     ir;

  logic [DW-1:0]   ra_data, rb_data;
  logic            rf_we;
  logic [DW-1:0]   rf_wd;

  opcode_t         dec_op;
  logic            is_sub;

  mc_regfile #(.NREG(NREG), .DW(DW)) u_regfile (
    .clk     (Clk),
    .rst     (Reset),
    .ra_addr (ir[RA_MSB:RA_LSB]),
    .rb_addr (ir[RB_MSB:RB_LSB]),
    .ra_data (ra_data),
    .rb_data (rb_data),
    .we      (rf_we),
    .wa      (ir[RD_MSB:RD_LSB]),
    .wd      (rf_wd)
  );

  // The next state is chosen from the ROM word itself while IR is loaded.
  assign dec_op = opcode_t'(bus.IM_Data[OP_MSB:OP_LSB]);
  assign is_sub = (ir[OP_MSB:OP_LSB] == OP_SUB);

  always_comb begin
    next_state = S_INIT;
    case (state)
      S_INIT:   next_state = S_FETCH;
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        case (dec_op)
          OP_STORE: next_state = S_STORE;
          OP_LOAD:  next_state = S_LOAD_A;
          OP_ADD:   next_state = S_ALU;
          OP_SUB:   next_state = S_ALU;
          OP_HALT:  next_state = S_HALT;
          OP_LDI:   next_state = S_LDI;
          OP_JZ:    next_state = S_JZ;
          default:  next_state = S_FETCH;
        endcase
      end
      S_LOAD_A: next_state = S_LOAD_B;
      S_LOAD_B: next_state = S_FETCH;
      S_STORE:  next_state = S_FETCH;
      S_ALU:    next_state = S_FETCH;
      S_LDI:    next_state = S_FETCH;
      S_JZ:     next_state = S_FETCH;
      S_HALT:   next_state = Run ? S_FETCH : S_HALT;
      default:  next_state = S_INIT;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= S_INIT;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= next_state;
      if (state == S_DECODE) begin
        ir <= bus.IM_Data;
        pc <= pc + 1'b1;
      end else if (state == S_JZ && ra_data == '0) begin
        pc <= PC_W'(ir[JT_MSB:JT_LSB]);
      end
    end
  end

  always_comb begin
    rf_we = 1'b0;
    rf_wd = '0;
    case (state)
      S_LOAD_B: begin
        rf_we = 1'b1;
        rf_wd = bus.D_RData;
      end
      S_ALU: begin
        rf_we = 1'b1;
        rf_wd = is_sub ? (ra_data - rb_data) : (ra_data + rb_data);
      end
      S_LDI: begin
        rf_we = 1'b1;
        rf_wd = DW'($signed(ir[IMM_MSB:IMM_LSB]));
      end
      default: ;
    endcase
  end

  // Memory outputs are decoded from the state alone, so an asynchronous
  // reset drops D_Wr in the same cycle.
  always_comb begin
    bus.D_Addr  = '0;
    bus.D_Wr    = 1'b0;
    bus.D_WData = '0;
    case (state)
      S_LOAD_A, S_LOAD_B: bus.D_Addr = ir[LADDR_MSB:LADDR_LSB];
      S_STORE: begin
        bus.D_Addr  = ir[SADDR_MSB:SADDR_LSB];
        bus.D_Wr    = 1'b1;
        bus.D_WData = ra_data;
      end
      default: ;
    endcase
  end

  assign bus.IM_Addr = pc;
  assign IR_Out      = ir;
  assign PC_Out      = pc;
  assign State       = state;
  assign Halted      = (state == S_HALT);
endmodule

// File: tb/tb_multicycle_core.sv
// Self-checking bench for multicycle_core: an instruction-level model
// produces the expected per-cycle trace, one loop compares every cycle.
module tb_multicycle_core;
  import mc_pkg::*;

  localparam int DW   = 16;
  localparam int PC_W = 7;
  localparam int NREG = 12;
  localparam int MAXC = 512;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic Run = 1'b0;
  always #5 Clk = ~Clk;

  // Main DUT
  multicycle_core_if #(.DW(DW), .PC_W(PC_W)) bus ();
  logic [15:0]     ir_out;
  logic [PC_W-1:0] pc_out;
  logic [3:0]      state;
  logic            halted;

  multicycle_core #(.DW(DW), .PC_W(PC_W), .NREG(NREG)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .bus(bus),
    .IR_Out(ir_out), .PC_Out(pc_out), .State(state), .Halted(halted)
  );

  // Small-PC DUT fed with NOOPs only, for the PC wrap check
  multicycle_core_if #(.DW(16), .PC_W(3)) bus2 ();
  logic [15:0] ir2;
  logic [2:0]  pc2;
  logic [3:0]  st2;
  logic        h2;
  assign bus2.IM_Data = '0;
  assign bus2.D_RData = '0;

  multicycle_core #(.DW(16), .PC_W(3), .NREG(4)) dut_wrap (
    .Clk(Clk), .Reset(Reset), .Run(1'b0), .bus(bus2),
    .IR_Out(ir2), .PC_Out(pc2), .State(st2), .Halted(h2)
  );

  // Memories
  logic [15:0]   rom [128];
  logic [DW-1:0] dmem [256];
  logic [DW-1:0] dmem_init [256];

  always @(posedge Clk) begin
    bus.IM_Data <= rom[bus.IM_Addr];
    if (bus.D_Wr) dmem[bus.D_Addr] <= bus.D_WData;
    bus.D_RData <= dmem[bus.D_Addr];
  end

  // Bookkeeping
  int checks = 0;
  int failures = 0;
  int cur_cycle = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cur_cycle, act, exp);
    end
  endtask

  // Reference model: executes whole instructions and emits the cycles each takes
  typedef struct packed {
    logic [3:0]      st;
    logic [PC_W-1:0] pc;
    logic [15:0]     ir;
    logic            wr;
    logic [7:0]      da;
    logic [DW-1:0]   wd;
    logic            halted;
  } exp_t;

  exp_t          ex [MAXC];
  bit            run_sched [MAXC];
  int            n_exp;
  logic [DW-1:0] m_reg [16];
  logic [DW-1:0] m_mem [256];

  function automatic logic [DW-1:0] m_rd(input logic [3:0] a);
    return (int'(a) < NREG) ? m_reg[a] : '0;
  endfunction

  function automatic void m_wr(input logic [3:0] a, input logic [DW-1:0] v);
    if (int'(a) < NREG) m_reg[a] = v;
  endfunction

  function automatic void emit(input logic [3:0] st, input int pc, input logic [15:0] ir,
                               input logic wr, input logic [7:0] da, input logic [DW-1:0] wd,
                               input logic h);
    if (n_exp < MAXC) begin
      ex[n_exp].st     = st;
      ex[n_exp].pc     = pc[PC_W-1:0];
      ex[n_exp].ir     = ir;
      ex[n_exp].wr     = wr;
      ex[n_exp].da     = da;
      ex[n_exp].wd     = wd;
      ex[n_exp].halted = h;
    end
    n_exp++;
  endfunction

  task automatic build(input int n);
    int            pc;
    int            s;
    logic [15:0]   ir;
    logic [15:0]   ins;
    logic [3:0]    a, b, d;
    logic [DW-1:0] v;
    pc = 0;
    ir = '0;
    n_exp = 0;
    for (int i = 0; i < 16; i++) m_reg[i] = '0;
    for (int i = 0; i < 256; i++) m_mem[i] = dmem_init[i];
    emit(S_INIT, 0, '0, 0, '0, '0, 0);
    while (n_exp < n) begin
      emit(S_FETCH, pc, ir, 0, '0, '0, 0);
      emit(S_DECODE, pc, ir, 0, '0, '0, 0);
      ins = rom[pc];
      ir  = ins;
      pc  = (pc + 1) % (1 << PC_W);
      a = ins[11:8];
      b = ins[7:4];
      d = ins[3:0];
      case (ins[15:12])
        4'd1: begin
          emit(S_STORE, pc, ir, 1, ins[7:0], m_rd(a), 0);
          m_mem[ins[7:0]] = m_rd(a);
        end
        4'd2: begin
          emit(S_LOAD_A, pc, ir, 0, ins[11:4], '0, 0);
          emit(S_LOAD_B, pc, ir, 0, ins[11:4], '0, 0);
          m_wr(d, m_mem[ins[11:4]]);
        end
        4'd3: begin
          emit(S_ALU, pc, ir, 0, '0, '0, 0);
          v = m_rd(a) + m_rd(b);
          m_wr(d, v);
        end
        4'd4: begin
          emit(S_ALU, pc, ir, 0, '0, '0, 0);
          v = m_rd(a) - m_rd(b);
          m_wr(d, v);
        end
        4'd5: begin
          do emit(S_HALT, pc, ir, 0, '0, '0, 1);
          while (n_exp < n && n_exp <= MAXC && !run_sched[n_exp-1]);
        end
        4'd6: begin
          emit(S_LDI, pc, ir, 0, '0, '0, 0);
          s = int'(ins[11:4]);
          if (s > 127) s = s - 256;
          v = s[DW-1:0];
          m_wr(d, v);
        end
        4'd7: begin
          emit(S_JZ, pc, ir, 0, '0, '0, 0);
          if (m_rd(a) == '0) pc = int'(ins[7:0]) % (1 << PC_W);
        end
        default: ;
      endcase
    end
  endtask

  // Observations for the hand-computed expectations
  logic [PC_W-1:0] obs_pc [MAXC];
  logic [3:0]      obs_st [MAXC];
  logic [7:0]      wr_a [$];
  logic [DW-1:0]   wr_d [$];

  task automatic reset_checks(input string tag);
    chk({tag, "_state"}, state, S_INIT);
    chk({tag, "_pc"}, pc_out, '0);
    chk({tag, "_ir"}, ir_out, '0);
    chk({tag, "_dwr"}, bus.D_Wr, 1'b0);
    chk({tag, "_halted"}, halted, 1'b0);
    chk({tag, "_daddr"}, bus.D_Addr, '0);
  endtask

  // Resets, releases, then compares every cycle against the model trace.
  // abort_at >= 0 reasserts Reset in that cycle and checks the immediate effect.
  task automatic run_prog(input int n, input int abort_at);
    build(n);
    for (int i = 0; i < 256; i++) dmem[i] = dmem_init[i];
    wr_a.delete();
    wr_d.delete();
    Reset = 1'b1;
    Run = 1'b0;
    repeat (2) @(negedge Clk);
    cur_cycle = -1;
    reset_checks("reset");
    Reset = 1'b0;
    for (int c = 0; c < n; c++) begin
      if (c > 0) @(negedge Clk);
      Run = run_sched[c];
      #1;
      cur_cycle = c;
      obs_pc[c] = pc_out;
      obs_st[c] = state;
      if (bus.D_Wr) begin
        wr_a.push_back(bus.D_Addr);
        wr_d.push_back(bus.D_WData);
      end
      chk("state", state, ex[c].st);
      chk("pc", pc_out, ex[c].pc);
      chk("im_addr", bus.IM_Addr, ex[c].pc);
      chk("ir", ir_out, ex[c].ir);
      chk("d_wr", bus.D_Wr, ex[c].wr);
      chk("d_addr", bus.D_Addr, ex[c].da);
      chk("d_wdata", bus.D_WData, ex[c].wd);
      chk("halted", halted, ex[c].halted);
      if (c >= 1 && c <= 17 && (c % 2) == 1) begin
        chk("wrap_pc", pc2, ((c - 1) / 2) % 8);
        chk("wrap_state", st2, S_FETCH);
      end
      if (c == abort_at) begin
        Reset = 1'b1;
        #1;
        reset_checks("abort");
        break;
      end
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 128; i++) rom[i] = '0;
    for (int i = 0; i < 256; i++) dmem_init[i] = '0;
    for (int i = 0; i < MAXC; i++) run_sched[i] = 1'b0;
  endtask

  initial begin
    // Load/arith/store program
    clear_prog();
    rom[0] = 16'h21B1; rom[1] = 16'h22A2; rom[2] = 16'h23C3; rom[3] = 16'h27E4;
    rom[4] = 16'h4125; rom[5] = 16'h3536; rom[6] = 16'h464A; rom[7] = 16'h1A6A;
    rom[8] = 16'h5000;
    dmem_init[8'h1B] = 16'h21BA; dmem_init[8'h2A] = 16'hA04E;
    dmem_init[8'h3C] = 16'h71AC; dmem_init[8'h7E] = 16'hB17F;
    run_prog(40, -1);
    cur_cycle = -1;
    chk("first_fetch_addr", obs_pc[1], 7'h00);
    chk("first_fetch_state", obs_st[1], S_FETCH);
    chk("prog_wr_count", wr_a.size(), 1);
    if (wr_a.size() > 0) begin
      chk("prog_wr_addr", wr_a[0], 8'h6A);
      // (21BA-A04E)=816C, +71AC=F318, -B17F=4199
      chk("prog_wr_data", wr_d[0], 16'h4199);
    end
    chk("prog_halted", obs_st[39], S_HALT);

    // LDI sign extension, observed through stores
    clear_prog();
    rom[0] = 16'h6FF3; rom[1] = 16'h6075; rom[2] = 16'h1300; rom[3] = 16'h1501;
    rom[4] = 16'h5000;
    run_prog(20, -1);
    cur_cycle = -1;
    chk("ldi_wr_count", wr_a.size(), 2);
    if (wr_d.size() == 2) begin
      chk("ldi_neg", wr_d[0], 16'hFFFF);
      chk("ldi_pos", wr_d[1], 16'h0007);
    end

    // JZ taken
    clear_prog();
    rom[0] = 16'h7210; rom[16] = 16'h5000;
    run_prog(8, -1);
    cur_cycle = -1;
    chk("jz_taken_addr", obs_pc[4], 7'h10);

    // JZ not taken
    clear_prog();
    rom[0] = 16'h6012; rom[1] = 16'h7210; rom[2] = 16'h5000;
    run_prog(10, -1);
    cur_cycle = -1;
    chk("jz_not_taken_addr", obs_pc[7], 7'h02);

    // HALT held 20 cycles, then Run
    clear_prog();
    rom[0] = 16'h5000;
    run_sched[22] = 1'b1;
    run_prog(28, -1);
    cur_cycle = -1;
    chk("halt_no_write", wr_a.size(), 0);
    chk("halt_pc_held", obs_pc[22], 7'h01);
    chk("resume_state", obs_st[23], S_FETCH);
    chk("resume_addr", obs_pc[23], 7'h01);

    // Reset during LOAD_B, then during STORE
    clear_prog();
    rom[0] = 16'h2051; rom[1] = 16'h1120; rom[2] = 16'h5000;
    dmem_init[8'h05] = 16'h1234;
    run_prog(10, 4);
    cur_cycle = -1;
    chk("abort_in_load_b", obs_st[4], S_LOAD_B);
    rom[0] = 16'h1120; rom[1] = 16'h5000; rom[2] = 16'h0000;
    run_prog(8, 3);
    cur_cycle = -1;
    chk("post_reset_store_count", wr_d.size(), 1);
    if (wr_d.size() == 1) chk("post_reset_r1", wr_d[0], 16'h0000);

    // Randomized programs with random Run activity
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 128; i++) begin
        logic [3:0]  op;
        logic [11:0] fld;
        op  = 4'($urandom_range(0, 15));
        if (op == 4'd5 && $urandom_range(0, 3) != 0) op = 4'd3;
        fld = 12'($urandom);
        rom[i] = {op, fld};
      end
      for (int i = 0; i < 256; i++) dmem_init[i] = DW'($urandom);
      for (int i = 0; i < MAXC; i++) run_sched[i] = ($urandom_range(0, 7) == 0);
      run_prog(400, -1);
    end

    Reset = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
